// File: rtl/fme_vhalf_win.sv
// Purpose: vertical half-pel 6-tap window stage over a sliding window of 20-pixel reference rows.
// Latency: 2 cycles from the firing input row to vhalf_valid_o; end_blk_o is also delayed 2 cycles.
// Backpressure: none; input gaps stall the window while the pipeline keeps draining.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module fme_vhalf_win #(
    parameter int BIT_DEPTH = `BIT_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [20*BIT_DEPTH-1:0] refdata_i,
    input  logic                    refdata_valid_i,
    input  logic                    area_co_locate_i,
    input  logic                    end_one_blk_rd_i,
    output logic [20*BIT_DEPTH-1:0] vhalf_o,
    output logic [20*BIT_DEPTH-1:0] fpel_o,
    output logic                    vhalf_valid_o,
    output logic                    colocate_o,
    output logic [4:0]              row_idx_o,
    output logic                    end_blk_o
);

    localparam int RW = 20 * BIT_DEPTH;
    localparam int SW = BIT_DEPTH + 7;
    localparam logic signed [SW-1:0] K5  = SW'(5);
    localparam logic signed [SW-1:0] K16 = SW'(16);
    localparam logic signed [SW-1:0] K20 = SW'(20);

    logic [RW-1:0]    w1_q, w2_q, w3_q, w4_q, w5_q;
    logic [5:1]       c_q;
    logic [2:0]       fill_q;
    logic [4:0]       row_idx_q;

    logic             a_vld_q;
    logic [20*SW-1:0] sa_q;
    logic [RW-1:0]    fa_q;
    logic             ca_q;
    logic [4:0]       ia_q;

    logic             b_vld_q;
    logic [RW-1:0]    vhalf_q, fpel_q;
    logic             cb_q;
    logic [4:0]       ib_q;
    logic             e1_q, e2_q;

    logic             fire;
    logic [20*SW-1:0] s_d;
    logic [RW-1:0]    vh_d;
    logic [2:0]       fill_d;

    assign fire   = refdata_valid_i & (fill_q == 3'd5);
    assign fill_d = (fill_q == 3'd5) ? fill_q : fill_q + 3'd1;

    for (genvar k = 0; k < 20; k++) begin : g_col
        logic signed [SW-1:0] t0, t1, t2, t3, t4, t5, r, v;
        assign t0 = $signed({7'b0, w1_q[k*BIT_DEPTH +: BIT_DEPTH]});
        assign t1 = $signed({7'b0, w2_q[k*BIT_DEPTH +: BIT_DEPTH]});
        assign t2 = $signed({7'b0, w3_q[k*BIT_DEPTH +: BIT_DEPTH]});
        assign t3 = $signed({7'b0, w4_q[k*BIT_DEPTH +: BIT_DEPTH]});
        assign t4 = $signed({7'b0, w5_q[k*BIT_DEPTH +: BIT_DEPTH]});
        assign t5 = $signed({7'b0, refdata_i[k*BIT_DEPTH +: BIT_DEPTH]});
        assign s_d[k*SW +: SW] = t0 - K5 * t1 + K20 * t2 + K20 * t3 - K5 * t4 + t5;

        // Round, arithmetic shift, then clip negatives to 0 and overflows to full scale.
        assign r = $signed(sa_q[k*SW +: SW]) + K16;
        assign v = r >>> 5;
        assign vh_d[k*BIT_DEPTH +: BIT_DEPTH] =
            v[SW-1]                 ? {BIT_DEPTH{1'b0}} :
            (|v[SW-2:BIT_DEPTH])    ? {BIT_DEPTH{1'b1}} :
                                      v[BIT_DEPTH-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w1_q <= '0; w2_q <= '0; w3_q <= '0; w4_q <= '0; w5_q <= '0;
            c_q       <= '0;
            fill_q    <= '0;
            row_idx_q <= '0;
            a_vld_q   <= 1'b0;
            sa_q      <= '0;
            fa_q      <= '0;
            ca_q      <= 1'b0;
            ia_q      <= '0;
            b_vld_q   <= 1'b0;
            vhalf_q   <= '0;
            fpel_q    <= '0;
            cb_q      <= 1'b0;
            ib_q      <= '0;
            e1_q      <= 1'b0;
            e2_q      <= 1'b0;
        end else if (flush_i) begin
            w1_q <= '0; w2_q <= '0; w3_q <= '0; w4_q <= '0; w5_q <= '0;
            c_q       <= '0;
            fill_q    <= '0;
            row_idx_q <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            e1_q      <= 1'b0;
            e2_q      <= 1'b0;
        end else begin
            if (refdata_valid_i) begin
                w1_q   <= w2_q;
                w2_q   <= w3_q;
                w3_q   <= w4_q;
                w4_q   <= w5_q;
                w5_q   <= refdata_i;
                c_q    <= {area_co_locate_i, c_q[5:2]};
                fill_q <= fill_d;
            end
            if (fire) begin
                row_idx_q <= row_idx_q + 5'd1;
                sa_q      <= s_d;
                fa_q      <= w3_q;
                ca_q      <= c_q[3];
                ia_q      <= row_idx_q;
            end
            // Block end wins over the increments above so the next block starts from an empty window.
            if (end_one_blk_rd_i) begin
                fill_q    <= '0;
                row_idx_q <= '0;
            end
            a_vld_q <= fire;
            b_vld_q <= a_vld_q;
            if (a_vld_q) begin
                vhalf_q <= vh_d;
                fpel_q  <= fa_q;
                cb_q    <= ca_q;
                ib_q    <= ia_q;
            end
            e1_q <= end_one_blk_rd_i;
            e2_q <= e1_q;
        end
    end

    assign vhalf_o       = vhalf_q;
    assign fpel_o        = fpel_q;
    assign vhalf_valid_o = b_vld_q;
    assign colocate_o    = cb_q;
    assign row_idx_o     = ib_q;
    assign end_blk_o     = e2_q;

endmodule
